// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters walk active, front porch, sync, back porch;
// every output is registered one cycle after the counter state it decodes.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic        busy_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] H_AEND = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [15:0] h_q, h_d, v_q, v_d;
  logic        last_h, last_frame, run;
  logic        de_act, hs_act, vs_act;

  logic        hs_q, vs_q, de_q, sof_q, eol_q, busy_q;
  logic [15:0] x_q, y_q;

  assign last_h     = (h_q == H_LAST);
  assign last_frame = last_h && (v_q == V_LAST);
  assign run        = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en_i) state_d = RUN;
      end
      RUN: begin
        h_d = last_h ? '0 : h_q + 16'd1;
        if (last_h) v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
        // A frame always completes; en is only consulted on its final cycle.
        if (last_frame && !en_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Counters sit at 0 in IDLE, so decodes must be gated by run.
  assign de_act = run && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_act = run && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act = run && (v_q >= VS_BEG) && (v_q < VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      busy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      hs_q   <= hs_act ? HS_POL : ~HS_POL;
      vs_q   <= vs_act ? VS_POL : ~VS_POL;
      de_q   <= de_act;
      sof_q  <= de_act && (h_q == '0) && (v_q == '0);
      eol_q  <= de_act && (h_q == H_AEND);
      busy_q <= run;
      x_q    <= de_act ? h_q : '0;
      y_q    <= de_act ? v_q : '0;
    end
  end

  assign hs_o   = hs_q;
  assign vs_o   = vs_q;
  assign de_o   = de_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign sof_o  = sof_q;
  assign eol_o  = eol_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster, with an active-high
// and an active-low sync instance driven from the same stimulus.
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 16, VT = 8, FR = 128;

  logic clk = 1'b0;
  logic rst_n, en;
  logic hs, vs, de, sof, eol, busy;
  logic [15:0] x, y;
  logic hs_n, vs_n, de_n, sof_n, eol_n, busy_n;
  logic [15:0] x_n, y_n;
  int n_cmp = 0, n_err = 0;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .hs_o(hs), .vs_o(vs), .de_o(de),
    .x_o(x), .y_o(y), .sof_o(sof), .eol_o(eol), .busy_o(busy));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .en_i(en), .hs_o(hs_n), .vs_o(vs_n), .de_o(de_n),
    .x_o(x_n), .y_o(y_n), .sof_o(sof_n), .eol_o(eol_n), .busy_o(busy_n));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Both instances in their deasserted state: syncs low / high respectively.
  task automatic idle_now(input string tag);
    chk({tag, "_ctl"}, 32'({busy, de, sof, eol, hs, vs, hs_n, vs_n, busy_n, de_n, sof_n, eol_n}),
        32'({6'b0, 2'b11, 4'b0}));
    chk({tag, "_xy"}, {x, y}, 32'd0);
    chk({tag, "_xy_n"}, {x_n, y_n}, 32'd0);
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_now(tag);
    end
  endtask

  // Sample k is the output registered k+1 edges after en was first seen high.
  task automatic observe(input int ncyc, input int drop_at);
    int h, v;
    logic de_e, hs_e, vs_e, sof_e, eol_e, hs_prev;
    logic [15:0] xe, ye;
    int n_sof, n_de, n_eol, n_hsr, n_vs, n_busy, de_run;
    n_sof = 0; n_de = 0; n_eol = 0; n_hsr = 0; n_vs = 0; n_busy = 0; de_run = 0;
    hs_prev = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      h = k % HT;
      v = (k / HT) % VT;
      de_e  = (h < HA) && (v < VA);
      hs_e  = (h >= HA + HF) && (h < HA + HF + HS);
      vs_e  = (v >= VA + VF) && (v < VA + VF + VS);
      sof_e = de_e && (h == 0) && (v == 0);
      eol_e = de_e && (h == HA - 1);
      xe = de_e ? 16'(h) : 16'd0;
      ye = de_e ? 16'(v) : 16'd0;
      chk("ctl", 32'({busy, de, sof, eol, hs, vs}), 32'({1'b1, de_e, sof_e, eol_e, hs_e, vs_e}));
      chk("xy", {x, y}, {xe, ye});
      chk("ctl_n", 32'({busy_n, de_n, sof_n, eol_n, hs_n, vs_n}),
          32'({1'b1, de_e, sof_e, eol_e, ~hs_e, ~vs_e}));
      chk("xy_n", {x_n, y_n}, {xe, ye});
      // Downstream de counter cleared on each hs rising edge.
      if (hs && !hs_prev) begin
        n_hsr++;
        chk("de_per_line", de_run, (v < VA) ? 32'd8 : 32'd0);
        de_run = 0;
      end
      if (de) de_run++;
      hs_prev = hs;
      n_sof += int'(sof); n_de += int'(de); n_eol += int'(eol);
      n_vs += int'(vs); n_busy += int'(busy);
      if (k % FR == FR - 1) begin
        chk("n_sof", n_sof, 1);
        chk("n_de", n_de, 32);
        chk("n_eol", n_eol, 4);
        chk("n_hs", n_hsr, 8);
        chk("n_vs", n_vs, 32);
        chk("n_busy", n_busy, 128);
        n_sof = 0; n_de = 0; n_eol = 0; n_hsr = 0; n_vs = 0; n_busy = 0;
      end
      if (k == drop_at) en = 1'b0;
    end
  endtask

  task automatic start_frame(input string tag);
    en = 1'b1;
    @(negedge clk);
    chk(tag, 32'({busy, de, busy_n, de_n}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    idle_chk(20, "rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk(10, "post_rst");

    // Single-cycle en pulse: exactly one frame.
    start_frame("pre_pulse");
    en = 1'b0;
    observe(FR, -1);
    idle_chk(20, "after_pulse");

    // en held for three frames, dropped in frame 3.
    start_frame("pre_3f");
    observe(3 * FR, 2 * FR + 40);
    idle_chk(20, "after_3f");

    // en dropped at cycle 40 of frame 2: frame 2 completes, no frame 3.
    start_frame("pre_drop");
    observe(2 * FR, FR + 40);
    idle_chk(20, "no_frame3");

    // Asynchronous reset at cycle 70, checked before the next clk edge.
    start_frame("pre_abort");
    en = 1'b0;
    observe(71, -1);
    #2 rst_n = 1'b0;
    #1 idle_now("async_rst");
    @(negedge clk);
    idle_now("in_rst");
    rst_n = 1'b1;
    start_frame("pre_fresh");
    en = 1'b0;
    observe(FR, -1);
    idle_chk(10, "after_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
